// File: rtl/wash_sequencer.sv
// Execution core of the washing register machine: fetches from the program ROM, runs timed
// actuator ops against an external tick, loops via a counter. Optional pause: WASH_SEQ_PAUSE_EN.
module wash_sequencer #(
  parameter logic [7:0] START_PC = 8'd2,
  parameter logic [7:0] IDLE_PC  = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        tick,
`ifdef WASH_SEQ_PAUSE_EN
  input  logic        pause,
`endif
  input  logic [15:0] instr,
  output logic [7:0]  pc,
  output logic        fill_valve,
  output logic        drain_valve,
  output logic        motor_fwd,
  output logic        motor_rev,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StExec, StTimed} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  timer_q, timer_d;
  // Actuator one-hot {rev, fwd, drain, fill}; sel_q remembers the op while act_q may be paused.
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  act_q, act_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [7:0]  opcode, operand, pc_inc;
  logic [3:0]  op_act;
  logic        hold;

  assign opcode  = instr[7:0];
  assign operand = instr[15:8];
  assign pc_inc  = pc_q + 8'd1;

`ifdef WASH_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    case (opcode)
      8'h02:   op_act = 4'b0001;
      8'h03:   op_act = 4'b0010;
      8'h04:   op_act = 4'b0100;
      8'h05:   op_act = 4'b1000;
      default: op_act = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    sel_d   = sel_q;
    act_d   = act_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = START_PC;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = StExec;
        end
      end
      StExec: begin
        case (opcode)
          8'h00: begin
            pc_d    = IDLE_PC;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
          8'h01, 8'h02, 8'h03, 8'h04, 8'h05: begin
            // A zero-length timed op is a plain 1-clk no-op.
            if (operand != 8'd0) begin
              timer_d = operand;
              sel_d   = op_act;
              act_d   = op_act;
              state_d = StTimed;
            end else begin
              pc_d = pc_inc;
            end
          end
          8'h11: begin
            cnt_d = operand;
            pc_d  = pc_inc;
          end
          8'h12: begin
            cnt_d = cnt_q - 8'd1;
            pc_d  = pc_inc;
          end
          8'h21:   pc_d = (cnt_q == 8'd0) ? operand : pc_inc;
          8'h22:   pc_d = (cnt_q != 8'd0) ? operand : pc_inc;
          default: begin
            err_d   = 1'b1;
            pc_d    = IDLE_PC;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        endcase
      end
      StTimed: begin
        act_d = hold ? 4'b0000 : sel_q;
        if (tick && !hold) begin
          timer_d = timer_q - 8'd1;
          if (timer_q == 8'd1) begin
            act_d   = 4'b0000;
            pc_d    = pc_inc;
            state_d = StExec;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= IDLE_PC;
      cnt_q   <= 8'd0;
      timer_q <= 8'd0;
      sel_q   <= 4'b0000;
      act_q   <= 4'b0000;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      sel_q   <= sel_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign pc          = pc_q;
  assign fill_valve  = act_q[0];
  assign drain_valve = act_q[1];
  assign motor_fwd   = act_q[2];
  assign motor_rev   = act_q[3];
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: instruction-level reference interpreter checked every clock,
// directed program scenarios plus randomized programs and inputs.
module tb_wash_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        tick;
  logic        pause;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic        fill_valve, drain_valve, motor_fwd, motor_rev, busy, err;

  logic [15:0] rom [256];

  int n_checks = 0;
  int n_bad    = 0;
  int hi_fill, hi_drain, hi_fwd, hi_rev;

  // Reference interpreter state: mode 0 idle, 1 executing, 2 inside a timed op.
  int m_mode, m_pc, m_cnt, m_left, m_kind, m_act, m_err;

  assign instr = rom[pc];

  wash_sequencer #(
    .START_PC(8'd2),
    .IDLE_PC (8'd0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .tick       (tick),
`ifdef WASH_SEQ_PAUSE_EN
    .pause      (pause),
`endif
    .instr      (instr),
    .pc         (pc),
    .fill_valve (fill_valve),
    .drain_valve(drain_valve),
    .motor_fwd  (motor_fwd),
    .motor_rev  (motor_rev),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int op, arg, nxt;
    bit paused;
`ifdef WASH_SEQ_PAUSE_EN
    paused = pause;
`else
    paused = 1'b0;
`endif
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_left = 0; m_kind = 0; m_act = 0; m_err = 0;
      return;
    end
    op  = int'(rom[m_pc][7:0]);
    arg = int'(rom[m_pc][15:8]);
    nxt = (m_pc + 1) % 256;
    case (m_mode)
      0: if (start) begin m_pc = 2; m_err = 0; m_mode = 1; end
      1: begin
        if (op == 0) begin
          m_pc = 0; m_mode = 0;
        end else if (op >= 1 && op <= 5) begin
          if (arg == 0) m_pc = nxt;
          else begin m_left = arg; m_kind = op; m_act = op; m_mode = 2; end
        end else if (op == 'h11) begin
          m_cnt = arg; m_pc = nxt;
        end else if (op == 'h12) begin
          m_cnt = (m_cnt + 255) % 256; m_pc = nxt;
        end else if (op == 'h21) begin
          m_pc = (m_cnt == 0) ? arg : nxt;
        end else if (op == 'h22) begin
          m_pc = (m_cnt != 0) ? arg : nxt;
        end else begin
          m_err = 1; m_pc = 0; m_mode = 0;
        end
      end
      default: begin
        if (tick && !paused) begin
          m_left--;
          if (m_left == 0) begin m_pc = nxt; m_mode = 1; end
        end
        m_act = (m_mode == 2 && !paused) ? m_kind : 0;
      end
    endcase
  endtask

  // One clock: tally ticks seen by each actuator, advance the model, compare after the edge.
  task automatic step();
    logic [3:0] exp_act;
    if (tick) begin
      if (fill_valve)  hi_fill++;
      if (drain_valve) hi_drain++;
      if (motor_fwd)   hi_fwd++;
      if (motor_rev)   hi_rev++;
    end
    model_edge();
    @(posedge clk);
    #1;
    exp_act = {m_act == 5, m_act == 4, m_act == 3, m_act == 2};
    check_eq("pc", 32'(pc), 32'(m_pc));
    check_eq("busy", 32'(busy), 32'(m_mode != 0));
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("act", 32'({motor_rev, motor_fwd, drain_valve, fill_valve}), 32'(exp_act));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; tick = 1'b0; pause = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_counts();
    hi_fill = 0; hi_drain = 0; hi_fwd = 0; hi_rev = 0;
  endtask

  int k, pticks;
  bit done;
  logic [7:0] ops [11];

  initial begin
    ops[0] = 8'h00; ops[1] = 8'h01; ops[2] = 8'h02; ops[3] = 8'h03; ops[4] = 8'h04;
    ops[5] = 8'h05; ops[6] = 8'h11; ops[7] = 8'h12; ops[8] = 8'h21; ops[9] = 8'h22;
    ops[10] = 8'h7F;
    m_mode = 0; m_pc = 0; m_cnt = 0; m_left = 0; m_kind = 0; m_act = 0; m_err = 0;
    clear_counts();
    clear_rom();
    do_reset();

    // Reset state, and the halt at pc 0 must never run while idle.
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_act", 32'({motor_rev, motor_fwd, drain_valve, fill_valve}), 32'd0);
    for (int i = 0; i < 5; i++) begin tick = (i % 2 == 0); step(); end
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Wash program.
    clear_rom();
    rom[2] = {8'd100, 8'h02}; rom[3] = {8'd50, 8'h01}; rom[4] = {8'd5, 8'h11};
    rom[5] = {8'd20, 8'h04};  rom[6] = {8'd10, 8'h01}; rom[7] = {8'd20, 8'h05};
    rom[8] = {8'd10, 8'h01};  rom[9] = {8'd0, 8'h12};  rom[10] = {8'd5, 8'h22};
    rom[11] = {8'd100, 8'h03}; rom[12] = 16'h0000;
    tick = 1'b0;
    pulse_start();
    clear_counts();
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      tick = (i % 4 == 0);
      step();
      if (!busy) done = 1'b1;
    end
    check_eq("wash_finished", 32'(done), 32'd1);
    check_eq("wash_fill_ticks", 32'(hi_fill), 32'd100);
    check_eq("wash_fwd_ticks", 32'(hi_fwd), 32'd100);
    check_eq("wash_rev_ticks", 32'(hi_rev), 32'd100);
    check_eq("wash_drain_ticks", 32'(hi_drain), 32'd100);
    check_eq("wash_end_pc", 32'(pc), 32'd0);
    check_eq("wash_end_err", 32'(err), 32'd0);

    // Counter wrap and conditional jumps.
    clear_rom();
    rom[2] = {8'd0, 8'h11}; rom[3] = {8'd0, 8'h12}; rom[4] = {8'd40, 8'h21};
    rom[5] = {8'd0, 8'h11}; rom[6] = {8'd40, 8'h21}; rom[40] = 16'h0000;
    tick = 1'b0;
    pulse_start();
    check_eq("jz_start_pc", 32'(pc), 32'd2);
    step(); step(); step();
    check_eq("jz_not_taken", 32'(pc), 32'd5);
    step(); step();
    check_eq("jz_taken", 32'(pc), 32'd40);
    step();
    check_eq("jz_halt_busy", 32'(busy), 32'd0);

    // Zero-length fill.
    clear_rom();
    rom[2] = {8'd0, 8'h02};
    pulse_start();
    tick = 1'b1;
    step();
    check_eq("fill0_pc", 32'(pc), 32'd3);
    check_eq("fill0_valve", 32'(fill_valve), 32'd0);
    tick = 1'b0;
    step();

    // Illegal opcode.
    clear_rom();
    rom[2] = {8'd1, 8'h11}; rom[3] = 16'h007F;
    pulse_start();
    step(); step();
    check_eq("illegal_err", 32'(err), 32'd1);
    check_eq("illegal_busy", 32'(busy), 32'd0);
    check_eq("illegal_pc", 32'(pc), 32'd0);
    pulse_start();
    check_eq("restart_err", 32'(err), 32'd0);
    check_eq("restart_busy", 32'(busy), 32'd1);
    step(); step();

    // Reset mid forward.
    clear_rom();
    rom[2] = {8'd20, 8'h04};
    pulse_start();
    step();
    check_eq("fwd_on", 32'(motor_fwd), 32'd1);
    for (int i = 0; i < 6; i++) begin tick = (i % 2 == 0); step(); end
    tick = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("rst_fwd_off", 32'(motor_fwd), 32'd0);
    check_eq("rst_mid_pc", 32'(pc), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);

`ifdef WASH_SEQ_PAUSE_EN
    // Pause for 10 ticks mid fill 30; toggles placed on tick-free cycles.
    clear_rom();
    rom[2] = {8'd30, 8'h02};
    pulse_start();
    clear_counts();
    pticks = 0;
    done = 1'b0;
    k = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick = (i % 2 == 0);
      if (k == 0 && hi_fill >= 10 && !tick) begin pause = 1'b1; k = 1; end
      if (k == 1 && pticks >= 10 && !tick) begin pause = 1'b0; k = 2; end
      if (pause && tick) begin
        pticks++;
        check_eq("pause_fill_low", 32'(fill_valve), 32'd0);
      end
      step();
      if (!busy) done = 1'b1;
    end
    check_eq("pause_finished", 32'(done), 32'd1);
    check_eq("pause_ticks", 32'(pticks), 32'd10);
    check_eq("pause_fill_total", 32'(hi_fill), 32'd30);
`endif

    // Random programs and inputs against the reference interpreter.
    for (int p = 0; p < 20; p++) begin
      clear_rom();
      for (int a = 2; a < 16; a++) begin
        logic [7:0] op, arg;
        op = ops[$urandom_range(1, 10)];
        if ($urandom_range(0, 15) == 0) op = 8'h00;
        if (op == 8'h7F && $urandom_range(0, 3) != 0) op = 8'h12;
        case (op)
          8'h21, 8'h22: arg = 8'($urandom_range(0, 15));
          8'h11:        arg = 8'($urandom_range(0, 3));
          default:      arg = 8'($urandom_range(0, 3));
        endcase
        rom[a] = {arg, op};
      end
      do_reset();
      for (int c = 0; c < 200; c++) begin
        start = ($urandom_range(0, 19) == 0);
        tick  = ($urandom_range(0, 2) == 0);
`ifdef WASH_SEQ_PAUSE_EN
        pause = ($urandom_range(0, 4) == 0);
`endif
        rst_n = ($urandom_range(0, 149) != 0);
        step();
      end
      rst_n = 1'b1; start = 1'b0; pause = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
